// File: rtl/alu_pkg.sv
// Shared constants and FSM encoding for the ALU operation sequencer.
package alu_pkg;

   localparam int unsigned ALU_DW   = 32;
   localparam int unsigned ALU_SELW = 3;

   localparam logic [2:0] SEL_ADD = 3'b000;
   localparam logic [2:0] SEL_SUB = 3'b001;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StResp = 2'd2
   } alu_seq_state_e;

endpackage

// File: rtl/alu_seq_flags.sv
// Architectural Z/C/V flag register: capture of a completed op beats a same-cycle clear.
module alu_seq_flags (
   input  logic clk,
   input  logic rst_n,
   input  logic cap,
   input  logic clr,
   input  logic cap_z,
   input  logic cap_c,
   input  logic cap_v,
   output logic flag_z,
   output logic flag_c,
   output logic flag_v
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_z <= 1'b0;
         flag_c <= 1'b0;
         flag_v <= 1'b0;
      end else if (cap) begin
         flag_z <= cap_z;
         flag_c <= cap_c;
         flag_v <= cap_v;
      end else if (clr) begin
         flag_z <= 1'b0;
         flag_c <= 1'b0;
         flag_v <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequencer for an external combinational ALU: issue, capture, respond; one op in flight.
// Optional ALU_SEQ_CMP_EN adds req_cmp: compare-only ops update flags but produce no response.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned DW    = ALU_DW,
   parameter int unsigned SELW  = ALU_SELW,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [DW-1:0]    req_opa,
   input  logic [DW-1:0]    req_opb,
   input  logic [SELW-1:0]  req_sel,
`ifdef ALU_SEQ_CMP_EN
   input  logic             req_cmp,
`endif
   output logic [DW-1:0]    alu_opa,
   output logic [DW-1:0]    alu_opb,
   output logic [SELW-1:0]  alu_sel,
   input  logic [DW-1:0]    alu_res,
   input  logic             alu_z,
   input  logic             alu_c,
   input  logic             alu_v,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [DW-1:0]    rsp_res,
   output logic             rsp_z,
   output logic             rsp_c,
   output logic             rsp_v,
   input  logic             flag_clr,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic [CNT_W-1:0] op_cnt
);

   alu_seq_state_e state_q, state_d;
   logic           accept;
   logic           capture;
   logic           rsp_fire;
   logic           cmp_q;

`ifdef ALU_SEQ_CMP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_q <= 1'b0;
      end else if (accept) begin
         cmp_q <= req_cmp;
      end
   end
`else
   assign cmp_q = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      capture   = 1'b0;
      rsp_fire  = 1'b0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept  = 1'b1;
               state_d = StExec;
            end
         end
         StExec: begin
            capture = 1'b1;
            state_d = cmp_q ? StIdle : StResp;
         end
         StResp: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               rsp_fire = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // alu_* only move on accept so the ALU inputs stay quiet while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_opa <= '0;
         alu_opb <= '0;
         alu_sel <= '0;
      end else if (accept) begin
         alu_opa <= req_opa;
         alu_opb <= req_opb;
         alu_sel <= req_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_res <= '0;
         rsp_z   <= 1'b0;
         rsp_c   <= 1'b0;
         rsp_v   <= 1'b0;
      end else if (capture && !cmp_q) begin
         rsp_res <= alu_res;
         rsp_z   <= alu_z;
         rsp_c   <= alu_c;
         rsp_v   <= alu_v;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_cnt <= '0;
      end else if (rsp_fire) begin
         op_cnt <= op_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   alu_seq_flags u_flags (
      .clk    (clk),
      .rst_n  (rst_n),
      .cap    (capture),
      .clr    (flag_clr),
      .cap_z  (alu_z),
      .cap_c  (alu_c),
      .cap_v  (alu_v),
      .flag_z (flag_z),
      .flag_c (flag_c),
      .flag_v (flag_v)
   );

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq with a behavioural ALU; counter narrowed to 4 bits to reach wrap.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int unsigned CW = 4;

   typedef struct packed {
      logic [31:0] res;
      logic        z;
      logic        c;
      logic        v;
   } alu_out_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready, req_cmp;
   logic [31:0]   req_opa, req_opb;
   logic [2:0]    req_sel;
   logic [31:0]   alu_opa, alu_opb, alu_res;
   logic [2:0]    alu_sel;
   logic          alu_z, alu_c, alu_v;
   logic          rsp_valid, rsp_ready;
   logic [31:0]   rsp_res;
   logic          rsp_z, rsp_c, rsp_v;
   logic          flag_clr, flag_z, flag_c, flag_v;
   logic [CW-1:0] op_cnt;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   // Reference ALU semantics; C on SUB means borrow
   function automatic alu_out_t ref_alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] s);
      alu_out_t o;
      logic [32:0] w;
      o = '0;
      case (s)
         SEL_ADD: begin
            w     = {1'b0, a} + {1'b0, b};
            o.res = w[31:0];
            o.c   = w[32];
            o.v   = (a[31] == b[31]) && (o.res[31] != a[31]);
         end
         SEL_SUB: begin
            o.res = a - b;
            o.c   = (a < b);
            o.v   = (a[31] != b[31]) && (o.res[31] != a[31]);
         end
         3'd2: o.res = a & b;
         3'd3: o.res = a | b;
         3'd4: o.res = a ^ b;
         3'd5: o.res = a << b[4:0];
         3'd6: o.res = a >> b[4:0];
         default: o.res = ~a;
      endcase
      o.z = (o.res == 32'd0);
      return o;
   endfunction

   assign {alu_res, alu_z, alu_c, alu_v} = ref_alu(alu_opa, alu_opb, alu_sel);

   alu_seq #(
      .DW    (32),
      .SELW  (3),
      .CNT_W (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_opa   (req_opa),
      .req_opb   (req_opb),
      .req_sel   (req_sel),
`ifdef ALU_SEQ_CMP_EN
      .req_cmp   (req_cmp),
`endif
      .alu_opa   (alu_opa),
      .alu_opb   (alu_opb),
      .alu_sel   (alu_sel),
      .alu_res   (alu_res),
      .alu_z     (alu_z),
      .alu_c     (alu_c),
      .alu_v     (alu_v),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_res   (rsp_res),
      .rsp_z     (rsp_z),
      .rsp_c     (rsp_c),
      .rsp_v     (rsp_v),
      .flag_clr  (flag_clr),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .flag_v    (flag_v),
      .op_cnt    (op_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one cycle while the sequencer is idle
   task automatic present(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s,
                          input logic cmp);
      req_opa   = a;
      req_opb   = b;
      req_sel   = s;
      req_cmp   = cmp;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      req_cmp   = 1'b0;
   endtask

   // Cycles waited for rsp_valid after the accept edge, -1 on timeout
   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_valid && n < 16) begin
         tick();
         n++;
      end
      if (!rsp_valid) n = -1;
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_cnt = (exp_cnt + 1) % (1 << CW);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 1'b0; req_cmp = 1'b0; req_opa = '0; req_opb = '0; req_sel = '0;
      rsp_ready = 1'b0; flag_clr = 1'b0;
      #2;
      n_cmp++;
      if ({req_ready, rsp_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_hs: got ready/valid=%b want 10", {req_ready, rsp_valid});
      end
      n_cmp++;
      if ({alu_opa, alu_opb, alu_sel, rsp_res, rsp_z, rsp_c, rsp_v, flag_z, flag_c, flag_v,
           op_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_regs: got opa=%h opb=%h sel=%b res=%h rsp=%b%b%b flg=%b%b%b cnt=%0d want all 0",
                  alu_opa, alu_opb, alu_sel, rsp_res, rsp_z, rsp_c, rsp_v, flag_z, flag_c,
                  flag_v, op_cnt);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      exp_cnt = 0;
   endtask

   // Directed op: checks EXEC state, latency from request cycle, response, flags and count
   task automatic test_directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] s, input logic [34:0] want);
      int n;
      present(a, b, s, 1'b0);
      n_cmp++;
      if (rsp_valid !== 1'b0 || alu_opa !== a || alu_opb !== b || alu_sel !== s) begin
         n_fail++;
         $display("FAIL %s_issue: got valid=%b opa=%h opb=%h sel=%b want 0 %h %h %b",
                  nm, rsp_valid, alu_opa, alu_opb, alu_sel, a, b, s);
      end
      wait_rsp(n);
      n_cmp++;
      if (n != 1) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d cycles after request want 2", nm, n + 1);
      end
      n_cmp++;
      if ({rsp_res, rsp_z, rsp_c, rsp_v} !== want) begin
         n_fail++;
         $display("FAIL %s_rsp: got %h z%b c%b v%b want %h z%b c%b v%b", nm, rsp_res, rsp_z,
                  rsp_c, rsp_v, want[34:3], want[2], want[1], want[0]);
      end
      n_cmp++;
      if ({flag_z, flag_c, flag_v} !== want[2:0]) begin
         n_fail++;
         $display("FAIL %s_flags: got %b want %b", nm, {flag_z, flag_c, flag_v}, want[2:0]);
      end
      handshake();
      n_cmp++;
      if (op_cnt !== CW'(exp_cnt) || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_done: got cnt=%0d valid=%b ready=%b want %0d 0 1", nm, op_cnt,
                  rsp_valid, req_ready, exp_cnt);
      end
   endtask

   task automatic test_stall();
      int n;
      alu_out_t e1, e2;
      logic [31:0] a2;
      e1 = ref_alu(32'h1234_5678, 32'h0F0F_0F0F, SEL_SUB);
      a2 = 32'hCAFE_0001;
      e2 = ref_alu(a2, 32'h0000_00FF, 3'd2);
      present(32'h1234_5678, 32'h0F0F_0F0F, SEL_SUB, 1'b0);
      wait_rsp(n);
      req_opa = a2; req_opb = 32'h0000_00FF; req_sel = 3'd2; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || {rsp_res, rsp_z, rsp_c, rsp_v} !== e1
             || alu_opa !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got valid=%b ready=%b rsp=%h opa=%h want 1 0 %h 12345678",
                     i, rsp_valid, req_ready, {rsp_res, rsp_z, rsp_c, rsp_v}, alu_opa, e1);
         end
      end
      handshake();
      n_cmp++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_opa !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL stall_release: got ready=%b valid=%b opa=%h want 1 0 12345678",
                  req_ready, rsp_valid, alu_opa);
      end
      tick();
      req_valid = 1'b0;
      wait_rsp(n);
      n_cmp++;
      if (n != 1 || {rsp_res, rsp_z, rsp_c, rsp_v} !== e2) begin
         n_fail++;
         $display("FAIL stall_second: got wait=%0d rsp=%h want 1 %h", n,
                  {rsp_res, rsp_z, rsp_c, rsp_v}, e2);
      end
      handshake();
   endtask

   task automatic test_flag_clr();
      present(32'h9000_0000, 32'h9000_0000, SEL_ADD, 1'b0);
      flag_clr = 1'b1;
      tick();
      n_cmp++;
      if ({flag_z, flag_c, flag_v} !== 3'b011) begin
         n_fail++;
         $display("FAIL flag_cap_wins: got %b want 011", {flag_z, flag_c, flag_v});
      end
      tick();
      flag_clr = 1'b0;
      n_cmp++;
      if ({flag_z, flag_c, flag_v} !== 3'b000 || {rsp_z, rsp_c, rsp_v} !== 3'b011) begin
         n_fail++;
         $display("FAIL flag_clear: got flags=%b rsp=%b want 000 011", {flag_z, flag_c, flag_v},
                  {rsp_z, rsp_c, rsp_v});
      end
      handshake();
   endtask

   task automatic test_reset_midop();
      bit seen;
      present(32'hFFFF_FFFF, 32'h0000_0001, SEL_ADD, 1'b0);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({req_ready, rsp_valid} !== 2'b10 || {alu_opa, alu_opb, alu_sel, rsp_res, rsp_z, rsp_c,
           rsp_v, flag_z, flag_c, flag_v, op_cnt} !== '0) begin
         n_fail++;
         $display("FAIL midop_reset: got ready=%b valid=%b opa=%h res=%h flg=%b cnt=%0d want 1 0 0 0 000 0",
                  req_ready, rsp_valid, alu_opa, rsp_res, {flag_z, flag_c, flag_v}, op_cnt);
      end
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (rsp_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen || op_cnt !== '0) begin
         n_fail++;
         $display("FAIL midop_norsp: got rsp_seen=%b cnt=%0d want 0 0", seen, op_cnt);
      end
      exp_cnt = 0;
   endtask

   task automatic test_random();
      int n;
      int bad;
      alu_out_t e;
      logic [31:0] a, b;
      logic [2:0] s;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         a = $urandom();
         b = $urandom();
         if ($urandom_range(0, 3) == 0) b = a;
         if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
         s = 3'($urandom_range(0, 7));
         e = ref_alu(a, b, s);
         present(a, b, s, 1'b0);
         wait_rsp(n);
         for (int k = $urandom_range(0, 2); k > 0; k--) tick();
         n_cmp++;
         if (n != 1 || {rsp_res, rsp_z, rsp_c, rsp_v} !== e ||
             {flag_z, flag_c, flag_v} !== {e.z, e.c, e.v}) begin
            n_fail++;
            $display("FAIL rand[%0d]: a=%h b=%h s=%0d got wait=%0d rsp=%h flg=%b want 1 %h %b",
                     i, a, b, s, n, {rsp_res, rsp_z, rsp_c, rsp_v}, {flag_z, flag_c, flag_v},
                     e, {e.z, e.c, e.v});
         end
         handshake();
         n_cmp++;
         if (op_cnt !== CW'(exp_cnt)) begin
            n_fail++;
            $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, op_cnt, exp_cnt);
         end
      end
   endtask

`ifdef ALU_SEQ_CMP_EN
   task automatic test_cmp();
      bit seen;
      present(32'h0000_0000, 32'h0000_0001, SEL_SUB, 1'b1);
      n_cmp++;
      if (req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL cmp_exec: got ready=%b want 0", req_ready);
      end
      tick();
      n_cmp++;
      if (req_ready !== 1'b1 || {flag_z, flag_c, flag_v} !== 3'b010) begin
         n_fail++;
         $display("FAIL cmp_return: got ready=%b flags=%b want 1 010", req_ready,
                  {flag_z, flag_c, flag_v});
      end
      seen = rsp_valid;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rsp_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen || op_cnt !== CW'(exp_cnt)) begin
         n_fail++;
         $display("FAIL cmp_norsp: got rsp_seen=%b cnt=%0d want 0 %0d", seen, op_cnt, exp_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed("add_ovf", 32'h4000_0000, 32'h4000_0000, SEL_ADD, {32'h8000_0000, 3'b001});
      test_directed("add_cv", 32'h9000_0000, 32'h9000_0000, SEL_ADD, {32'h2000_0000, 3'b011});
      test_directed("sub_z", 32'h0000_0001, 32'h0000_0001, SEL_SUB, {32'h0000_0000, 3'b100});
      test_directed("sub_nz", 32'h0000_0006, 32'h0000_0001, SEL_SUB, {32'h0000_0005, 3'b000});
      test_stall();
      test_flag_clr();
`ifdef ALU_SEQ_CMP_EN
      test_directed("pre_cmp", 32'h0000_0001, 32'h0000_0001, SEL_SUB, {32'h0000_0000, 3'b100});
      test_cmp();
`endif
      test_reset_midop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
